// File: rtl/aes_round_seq.sv
// AES round sequencer: Moore FSM issuing S-box, key-schedule and round controls for
// single-round, last-round, full-cipher and AESKEYGENASSIST ops. Optional abort_i via AES_ROUND_SEQ_ABORT_EN.
package aes_pkg;
  typedef enum logic [2:0] {
    NOOP            = 3'd0,
    AESENC          = 3'd1,
    AESENCLAST      = 3'd2,
    AESENCFULL      = 3'd3,
    AESKEYGENASSIST = 3'd4
  } opcode;

  typedef logic [0:3][7:0] aes_32;
endpackage

module aes_round_seq
  import aes_pkg::*;
#(
  parameter int MAX_NR = 14,
  parameter int RND_W  = 4
) (
  input  logic             clk,
  input  logic             nrst,
`ifdef AES_ROUND_SEQ_ABORT_EN
  input  logic             abort_i,
`endif
  input  logic             start_i,
  input  opcode            opcode_i,
  input  logic [1:0]       key_len_i,
  output logic             busy_o,
  output logic             cipher_ready_o,
  output logic             key_ready_o,
  output logic             full_enc_o,
  output logic             final_rnd_o,
  output logic             zero_rnd_o,
  output logic             key_sel_o,
  output logic             en_rnd_o,
  output logic             en_key_o,
  output logic             key_sub_o,
  output logic             gen_key_o,
  output logic             next_rnd_o,
  output logic [RND_W-1:0] rnd_num_o,
  output aes_32            r_con_o
);

  typedef enum logic [1:0] {IDLE, SBOX, ROUND, FINISH} state_t;

  typedef struct packed {
    logic busy;
    logic cipher_ready;
    logic key_ready;
    logic full_enc;
    logic final_rnd;
    logic zero_rnd;
    logic key_sel;
    logic en_rnd;
    logic en_key;
    logic key_sub;
    logic gen_key;
    logic next_rnd;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{
    busy: 1'b0, cipher_ready: 1'b0, key_ready: 1'b0,
    full_enc: 1'b1, final_rnd: 1'b1, zero_rnd: 1'b0, key_sel: 1'b0,
    en_rnd: 1'b1, en_key: 1'b1, key_sub: 1'b0, gen_key: 1'b0, next_rnd: 1'b0
  };

  state_t           state_q, state_d;
  opcode            op_q, op_d;
  logic [RND_W-1:0] nr_q, nr_d;
  logic [RND_W-1:0] rnd_q, rnd_d;
  logic [7:0]       rcon_q, rcon_d;
  ctl_t             ctl_q, ctl_d;

  function automatic logic [RND_W-1:0] nr_of(input logic [1:0] kl);
    int n;
    case (kl)
      2'b01:   n = 12;
      2'b10:   n = 14;
      default: n = 10;
    endcase
    if (n > MAX_NR) n = MAX_NR;
    return RND_W'(n);
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Controls are decoded from the next-state values and then registered, so every
  // output is a pure function of the registered state (Moore) with no output glitching.
  function automatic ctl_t decode(input state_t s, input opcode op,
                                  input logic [RND_W-1:0] rnd, input logic [RND_W-1:0] nr);
    ctl_t c;
    c = CTL_IDLE;
    case (s)
      SBOX: begin
        c.busy = 1'b1;
        if (op == AESENCFULL) begin
          c.gen_key  = 1'b1;
          c.key_sub  = 1'b0;
          c.zero_rnd = (rnd == '0);
          c.key_sel  = (rnd == '0);
        end else begin
          c.en_key = 1'b0;
        end
      end
      ROUND: begin
        c.busy = 1'b1;
        case (op)
          AESENC: begin
            c.full_enc = 1'b1; c.final_rnd = 1'b0; c.zero_rnd = 1'b1; c.key_sel = 1'b1;
            c.en_key   = 1'b0;
          end
          AESENCLAST: begin
            c.full_enc = 1'b0; c.final_rnd = 1'b1; c.zero_rnd = 1'b1; c.key_sel = 1'b0;
            c.en_key   = 1'b0;
          end
          AESENCFULL: begin
            c.next_rnd  = 1'b1;
            c.key_sub   = 1'b1;
            c.final_rnd = (rnd == nr);
          end
          AESKEYGENASSIST: begin
            c.en_rnd  = 1'b0;
            c.key_sub = 1'b1;
            c.gen_key = 1'b1;
          end
          default: ;
        endcase
      end
      FINISH: begin
        c.busy         = 1'b1;
        c.cipher_ready = (op != AESKEYGENASSIST);
        c.key_ready    = (op == AESKEYGENASSIST);
        c.en_key       = (op == AESKEYGENASSIST);
        c.en_rnd       = (op != AESKEYGENASSIST);
      end
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    nr_d    = nr_q;
    rnd_d   = rnd_q;
    rcon_d  = rcon_q;
    case (state_q)
      IDLE: begin
        rnd_d  = '0;
        rcon_d = 8'h01;
        if (start_i) begin
          op_d = opcode_i;
          nr_d = nr_of(key_len_i);
          case (opcode_i)
            AESENC, AESENCLAST, AESENCFULL: state_d = SBOX;
            AESKEYGENASSIST:                state_d = ROUND;
            default:                        state_d = IDLE;
          endcase
        end
      end
      SBOX: begin
        state_d = ROUND;
        // Rcon stays 01 for round 1 and doubles in GF(2^8) on every later round
        if (op_q == AESENCFULL) begin
          rnd_d = rnd_q + RND_W'(1);
          if (rnd_q != '0) rcon_d = xtime(rcon_q);
        end
      end
      ROUND: begin
        if (op_q == AESENCFULL && rnd_q != nr_q) state_d = SBOX;
        else                                     state_d = FINISH;
      end
      FINISH: begin
        state_d = IDLE;
        rnd_d   = '0;
        rcon_d  = 8'h01;
      end
      default: begin
        state_d = IDLE;
        rnd_d   = '0;
        rcon_d  = 8'h01;
      end
    endcase
`ifdef AES_ROUND_SEQ_ABORT_EN
    if (abort_i && state_q != IDLE) begin
      state_d = IDLE;
      rnd_d   = '0;
      rcon_d  = 8'h01;
    end
`endif
    ctl_d = decode(state_d, op_d, rnd_d, nr_d);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      op_q    <= NOOP;
      nr_q    <= RND_W'(10);
      rnd_q   <= '0;
      rcon_q  <= 8'h01;
      ctl_q   <= CTL_IDLE;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      nr_q    <= nr_d;
      rnd_q   <= rnd_d;
      rcon_q  <= rcon_d;
      ctl_q   <= ctl_d;
    end
  end

  assign busy_o         = ctl_q.busy;
  assign cipher_ready_o = ctl_q.cipher_ready;
  assign key_ready_o    = ctl_q.key_ready;
  assign full_enc_o     = ctl_q.full_enc;
  assign final_rnd_o    = ctl_q.final_rnd;
  assign zero_rnd_o     = ctl_q.zero_rnd;
  assign key_sel_o      = ctl_q.key_sel;
  assign en_rnd_o       = ctl_q.en_rnd;
  assign en_key_o       = ctl_q.en_key;
  assign key_sub_o      = ctl_q.key_sub;
  assign gen_key_o      = ctl_q.gen_key;
  assign next_rnd_o     = ctl_q.next_rnd;
  assign rnd_num_o      = rnd_q;
  assign r_con_o        = aes_32'({24'h000000, rcon_q});

endmodule

// File: tb/tb_aes_round_seq.sv
// Directed bench for aes_round_seq: stimulus pushes expected done events into a queue,
// a negedge monitor pops and checks kind and cycle of every done pulse.
module tb_aes_round_seq;
  import aes_pkg::*;

  logic        clk = 1'b0;
  logic        nrst;
  logic        start_i;
  opcode       opcode_i;
  logic [1:0]  key_len_i;
  logic        busy_o, cipher_ready_o, key_ready_o;
  logic        full_enc_o, final_rnd_o, zero_rnd_o, key_sel_o, en_rnd_o, en_key_o;
  logic        key_sub_o, gen_key_o, next_rnd_o;
  logic [3:0]  rnd_num_o;
  aes_32       r_con_o;
`ifdef AES_ROUND_SEQ_ABORT_EN
  logic        abort_i;
`endif

  aes_round_seq #(.MAX_NR(14), .RND_W(4)) dut (
    .clk(clk), .nrst(nrst),
`ifdef AES_ROUND_SEQ_ABORT_EN
    .abort_i(abort_i),
`endif
    .start_i(start_i), .opcode_i(opcode_i), .key_len_i(key_len_i),
    .busy_o(busy_o), .cipher_ready_o(cipher_ready_o), .key_ready_o(key_ready_o),
    .full_enc_o(full_enc_o), .final_rnd_o(final_rnd_o), .zero_rnd_o(zero_rnd_o),
    .key_sel_o(key_sel_o), .en_rnd_o(en_rnd_o), .en_key_o(en_key_o),
    .key_sub_o(key_sub_o), .gen_key_o(gen_key_o), .next_rnd_o(next_rnd_o),
    .rnd_num_o(rnd_num_o), .r_con_o(r_con_o)
  );

  always #5 clk = ~clk;

  typedef struct {bit key; int cyc;} exp_t;
  exp_t exp_q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  logic done_prev = 1'b0;
  logic [7:0] rcon_tab [1:14] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                  8'h80, 8'h1b, 8'h36, 8'h6c, 8'hd8, 8'hab, 8'h4d};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (nrst) begin
      if (done_prev) chk("done_width", {cipher_ready_o, key_ready_o}, 2'b00);
      if (cipher_ready_o || key_ready_o) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_done: got cipher=%b key=%b expected none (cycle %0d)",
                   cipher_ready_o, key_ready_o, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_kind", {cipher_ready_o, key_ready_o}, e.key ? 2'b01 : 2'b10);
          chk("done_cycle", cyc, e.cyc);
        end
      end
    end
    done_prev <= cipher_ready_o | key_ready_o;
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy_done"}, {busy_o, cipher_ready_o, key_ready_o}, 3'b000);
    chk({tag, "_rnd"}, rnd_num_o, 4'd0);
    chk({tag, "_rcon"}, r_con_o, 32'h00000001);
    chk({tag, "_ctl"}, {full_enc_o, final_rnd_o, zero_rnd_o, key_sel_o, en_rnd_o, en_key_o,
                        key_sub_o, gen_key_o, next_rnd_o}, 9'b110011000);
  endtask

  // Called at a negedge; the following posedge is the accepting edge.
  task automatic issue(input opcode op, input logic [1:0] kl, input int lat, input bit key);
    start_i = 1'b1; opcode_i = op; key_len_i = kl;
    exp_q.push_back('{key, cyc + lat});
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_chk++; n_err++;
      $display("FAIL %s_timeout: got %0d pending done events expected 0", tag, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    chk({tag, "_idle_after"}, busy_o, 1'b0);
  endtask

  task automatic run_full(input logic [1:0] kl, input int nr, input int inj, input int rst_at,
                          input int abt_at);
    issue(AESENCFULL, kl, 2 * nr + 1, 1'b0);
    chk("full_first_sbox", {gen_key_o, key_sub_o, zero_rnd_o, key_sel_o}, 4'b1011);
    chk("full_first_rnd", rnd_num_o, 4'd0);
    for (int r = 1; r <= nr; r++) begin
      if (r > 1) begin
        start_i = 1'b0;
        chk("full_sbox", {gen_key_o, key_sub_o, zero_rnd_o}, 3'b100);
        chk("full_sbox_rnd", rnd_num_o, r - 1);
      end
      @(negedge clk);
      chk("full_rnd", rnd_num_o, r);
      chk("full_rcon", r_con_o, {24'h0, rcon_tab[r]});
      chk("full_round_ctl", {next_rnd_o, key_sub_o, final_rnd_o}, {2'b11, r == nr});
      if (r == inj) begin
        start_i = 1'b1; opcode_i = AESKEYGENASSIST;
      end
      if (r == rst_at) begin
        nrst = 1'b0;
        exp_q.delete();
        #1 check_reset_vals("midrst");
        repeat (3) @(negedge clk);
        check_reset_vals("midrst_hold");
        nrst = 1'b1;
        @(negedge clk);
        return;
      end
`ifdef AES_ROUND_SEQ_ABORT_EN
      if (r == abt_at) begin
        abort_i = 1'b1;
        exp_q.delete();
        @(negedge clk);
        abort_i = 1'b0;
        chk("abort_busy", busy_o, 1'b0);
        chk("abort_rnd", rnd_num_o, 4'd0);
        chk("abort_rcon", r_con_o, 32'h00000001);
        repeat (4) @(negedge clk);
        chk("abort_no_done", {cipher_ready_o, key_ready_o}, 2'b00);
        return;
      end
`endif
      if (r < nr) @(negedge clk);
    end
    start_i = 1'b0;
    wait_done("full");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b0; start_i = 1'b0; opcode_i = NOOP; key_len_i = 2'b00;
`ifdef AES_ROUND_SEQ_ABORT_EN
    abort_i = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    nrst = 1'b1;
    @(negedge clk);

    issue(AESENC, 2'b00, 3, 1'b0);
    chk("enc_busy", busy_o, 1'b1);
    @(negedge clk);
    chk("enc_round", {full_enc_o, final_rnd_o, zero_rnd_o, key_sel_o, en_key_o}, 5'b10110);
    wait_done("enc");

    issue(AESENCLAST, 2'b00, 3, 1'b0);
    @(negedge clk);
    chk("last_round", {full_enc_o, final_rnd_o, zero_rnd_o, key_sel_o, en_key_o}, 5'b01100);
    wait_done("last");

    issue(AESKEYGENASSIST, 2'b01, 2, 1'b1);
    chk("kga_round", {en_rnd_o, key_sub_o}, 2'b01);
    wait_done("kga");

    start_i = 1'b1; opcode_i = NOOP;
    @(negedge clk);
    start_i = 1'b0;
    chk("noop_busy", busy_o, 1'b0);

    run_full(2'b00, 10, 0, 0, 0);
    run_full(2'b10, 14, 0, 0, 0);
    run_full(2'b11, 10, 0, 0, 0);

    // AESENC then AESKEYGENASSIST with start held high throughout
    start_i = 1'b1; opcode_i = AESENC; key_len_i = 2'b00;
    exp_q.push_back('{1'b0, cyc + 3});
    repeat (3) @(negedge clk);
    opcode_i = AESKEYGENASSIST;
    @(negedge clk);
    chk("b2b_gap_busy", busy_o, 1'b0);
    exp_q.push_back('{1'b1, cyc + 2});
    @(negedge clk);
    start_i = 1'b0;
    wait_done("b2b");

    run_full(2'b00, 10, 5, 0, 0);
    run_full(2'b00, 10, 0, 7, 0);
    issue(AESENC, 2'b00, 3, 1'b0);
    wait_done("enc_after_rst");
`ifdef AES_ROUND_SEQ_ABORT_EN
    run_full(2'b00, 10, 0, 0, 3);
    issue(AESENC, 2'b00, 3, 1'b0);
    wait_done("enc_after_abort");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
